// File: rtl/imm_gen_pipe.sv
// Immediate generator feeding a 2-entry output FIFO.
// Decode is combinational on inst_code; results are buffered and presented from the head entry.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RV64_OPS = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_code,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Imm_out,
    output logic [2:0]      fmt_out,
    output logic            illegal_out
);

    localparam logic [2:0] FMT_N  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_Z  = 3'd6;
    localparam logic [2:0] FMT_SH = 3'd7;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic            rv64_en;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_z;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_sh5;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    assign opcode   = inst_code[6:0];
    assign funct3   = inst_code[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign rv64_en  = (RV64_OPS != 0);

    assign imm_i   = {{(XLEN-12){inst_code[31]}}, inst_code[31:20]};
    assign imm_s   = {{(XLEN-12){inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
    assign imm_b   = {{(XLEN-13){inst_code[31]}}, inst_code[31], inst_code[7],
                      inst_code[30:25], inst_code[11:8], 1'b0};
    assign imm_j   = {{(XLEN-21){inst_code[31]}}, inst_code[31], inst_code[19:12],
                      inst_code[20], inst_code[30:21], 1'b0};
    assign imm_z   = {{(XLEN-5){1'b0}}, inst_code[19:15]};
    assign imm_sh5 = {{(XLEN-5){1'b0}}, inst_code[24:20]};

    // Only the upper-immediate and the native shift amount depend on the datapath width.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm_u  = {{32{inst_code[31]}}, inst_code[31:12], 12'b0};
            assign imm_sh = {58'b0, inst_code[25:20]};
        end else begin : g_xlen32
            assign imm_u  = {inst_code[31:12], 12'b0};
            assign imm_sh = imm_sh5;
        end
    endgenerate

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_N;
        dec_illegal = 1'b0;
        if (inst_code[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD, OP_JALR: begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
                OP_IMM: begin
                    if (is_shift) begin
                        dec_imm = imm_sh;
                        dec_fmt = FMT_SH;
                    end else begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end
                end
                OP_IMM_32: begin
                    if (!rv64_en) begin
                        dec_illegal = 1'b1;
                    end else if (is_shift) begin
                        dec_imm = imm_sh5;
                        dec_fmt = FMT_SH;
                    end else begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end
                end
                OP_STORE: begin
                    dec_imm = imm_s;
                    dec_fmt = FMT_S;
                end
                OP_BRANCH: begin
                    dec_imm = imm_b;
                    dec_fmt = FMT_B;
                end
                OP_LUI, OP_AUIPC: begin
                    dec_imm = imm_u;
                    dec_fmt = FMT_U;
                end
                OP_JAL: begin
                    dec_imm = imm_j;
                    dec_fmt = FMT_J;
                end
                OP_SYSTEM: begin
                    // Register-form CSR ops and ecall/ebreak carry no immediate.
                    if (funct3[2]) begin
                        dec_imm = imm_z;
                        dec_fmt = FMT_Z;
                    end
                end
                OP_OP, OP_MISC_MEM: begin
                    dec_fmt = FMT_N;
                end
                OP_OP_32: begin
                    dec_illegal = !rv64_en;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    logic [XLEN-1:0] mem_imm [2];
    logic [2:0]      mem_fmt [2];
    logic            mem_illegal [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed while count says the slot is live.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem_imm[wr_ptr]     <= dec_imm;
            mem_fmt[wr_ptr]     <= dec_fmt;
            mem_illegal[wr_ptr] <= dec_illegal;
        end
    end

    assign Imm_out     = out_valid ? mem_imm[rd_ptr]     : '0;
    assign fmt_out     = out_valid ? mem_fmt[rd_ptr]     : FMT_N;
    assign illegal_out = out_valid ? mem_illegal[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: an RV32 and an RV64 instance share stimulus and are compared
// each cycle against a queue-based reference model of decode plus 2-deep buffering.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst_code;
    logic        out_ready;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .RV64_OPS(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .inst_code(inst_code), .out_valid(out_valid32), .out_ready(out_ready),
        .Imm_out(imm32), .fmt_out(fmt32), .illegal_out(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_OPS(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst_code(inst_code), .out_valid(out_valid64), .out_ready(out_ready),
        .Imm_out(imm64), .fmt_out(fmt64), .illegal_out(ill64)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        longint s;
        s = longint'(v << (64 - bits));
        return 64'(s >>> (64 - bits));
    endfunction

    function automatic void mdl(input logic [31:0] w, input bit x64, input bit rv64,
                                output logic [63:0] imm, output logic [2:0] fmt,
                                output logic ill);
        logic [6:0] op;
        logic [2:0] f3;
        bit         shift;
        op    = w[6:0];
        f3    = w[14:12];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        imm   = '0;
        fmt   = 3'd0;
        ill   = 1'b0;
        if (w[1:0] != 2'b11) begin
            ill = 1'b1;
        end else if (op == 7'h03 || op == 7'h67 ||
                     ((op == 7'h13 || (op == 7'h1B && rv64)) && !shift)) begin
            imm = sext(64'(w[31:20]), 12);
            fmt = 3'd1;
        end else if (op == 7'h13) begin
            imm = x64 ? 64'(w[25:20]) : 64'(w[24:20]);
            fmt = 3'd7;
        end else if (op == 7'h1B && rv64) begin
            imm = 64'(w[24:20]);
            fmt = 3'd7;
        end else if (op == 7'h23) begin
            imm = sext(64'({w[31:25], w[11:7]}), 12);
            fmt = 3'd2;
        end else if (op == 7'h63) begin
            imm = sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
            fmt = 3'd3;
        end else if (op == 7'h37 || op == 7'h17) begin
            imm = sext(64'({w[31:12], 12'b0}), 32);
            fmt = 3'd4;
        end else if (op == 7'h6F) begin
            imm = sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
            fmt = 3'd5;
        end else if (op == 7'h73) begin
            if (w[14]) begin
                imm = 64'(w[19:15]);
                fmt = 3'd6;
            end
        end else if (op == 7'h33 || op == 7'h0F || (op == 7'h3B && rv64)) begin
            fmt = 3'd0;
        end else begin
            ill = 1'b1;
        end
        if (!x64) imm[63:32] = 32'b0;
    endfunction

    // Reference buffer: a queue of raw words, decoded only when they reach the head.
    always @(posedge clk) begin : model_upd
        bit do_push, do_pop;
        do_push = in_valid && (mq.size() < 2);
        do_pop  = out_ready && (mq.size() > 0);
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(inst_code);
        end
    end

    always @(negedge clk) begin : compare
        logic [63:0] ei32, ei64;
        logic [2:0]  ef32, ef64;
        logic        el32, el64;
        if (chk_en) begin
            ei32 = '0; ef32 = '0; el32 = 1'b0;
            ei64 = '0; ef64 = '0; el64 = 1'b0;
            if (mq.size() != 0) begin
                mdl(mq[0], 1'b0, 1'b0, ei32, ef32, el32);
                mdl(mq[0], 1'b1, 1'b1, ei64, ef64, el64);
            end
            check("out_valid32", 64'(out_valid32), 64'(mq.size() != 0));
            check("in_ready32",  64'(in_ready32),  64'(mq.size() != 2));
            check("imm32",       64'(imm32),       ei32);
            check("fmt32",       64'(fmt32),       64'(ef32));
            check("illegal32",   64'(ill32),       64'(el32));
            check("out_valid64", 64'(out_valid64), 64'(mq.size() != 0));
            check("in_ready64",  64'(in_ready64),  64'(mq.size() != 2));
            check("imm64",       imm64,            ei64);
            check("fmt64",       64'(fmt64),       64'(ef64));
            check("illegal64",   64'(ill64),       64'(el64));
        end
    end

    localparam logic [31:0] W_BEQ    = 32'h00320463;
    localparam logic [31:0] W_ADDI   = 32'hFFF00093;
    localparam logic [31:0] W_JAL    = 32'hFFDFF06F;
    localparam logic [31:0] W_SRAI   = 32'h4032D293;
    localparam logic [31:0] W_BAD    = 32'h0000000B;
    localparam logic [31:0] W_LUI_A  = 32'h123450B7;
    localparam logic [31:0] W_LUI_B  = 32'h80000037;
    localparam logic [31:0] W_CSRWI  = 32'h3407D073;
    localparam logic [31:0] W_SLLI63 = 32'h03F51513;

    logic [31:0] words [19] = '{
        W_BEQ, W_ADDI, W_JAL, W_SRAI, W_BAD, W_LUI_A, W_LUI_B, W_CSRWI,
        32'hFE112E23, 32'h0015159B, 32'h0000003B, 32'h00000033, 32'h0000000F,
        32'h00000010, 32'h34011073, 32'h00000073, 32'hFFFFF017, W_SLLI63, 32'hFFF5051B
    };

    initial begin : stim
        logic [63:0] pi;
        logic [2:0]  pf;
        logic        pl;
        int          cyc;
        int          idx;
        bit          acc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst_code = '0; out_ready = 1'b0;

        mdl(W_BEQ, 1'b0, 1'b0, pi, pf, pl);
        check("mdl_beq_imm", pi, 64'h8);
        check("mdl_beq_fmt", 64'(pf), 64'd3);
        mdl(W_JAL, 1'b1, 1'b1, pi, pf, pl);
        check("mdl_jal_imm", pi, 64'hFFFF_FFFF_FFFF_FFFC);
        mdl(W_SLLI63, 1'b1, 1'b1, pi, pf, pl);
        check("mdl_slli64", pi, 64'd63);
        mdl(W_SLLI63, 1'b0, 1'b0, pi, pf, pl);
        check("mdl_slli32", pi, 64'd31);
        mdl(W_CSRWI, 1'b0, 1'b0, pi, pf, pl);
        check("mdl_zimm", pi, 64'd15);
        mdl(32'h0000003B, 1'b0, 1'b0, pi, pf, pl);
        check("mdl_op32_rv32_ill", 64'(pl), 64'd1);
        mdl(32'h0000003B, 1'b1, 1'b1, pi, pf, pl);
        check("mdl_op32_rv64_ill", 64'(pl), 64'd0);

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(out_valid32), 64'd0);
        check("rst_ready", 64'(in_ready32), 64'd1);
        check("rst_imm", imm64, 64'd0);

        // Single beq, consumer always ready.
        out_ready = 1'b1; in_valid = 1'b1; inst_code = W_BEQ;
        @(negedge clk);
        in_valid = 1'b0;
        check("beq_valid", 64'(out_valid32), 64'd1);
        check("beq_imm", 64'(imm32), 64'h8);
        check("beq_fmt", 64'(fmt32), 64'd3);
        check("beq_ill", 64'(ill32), 64'd0);
        @(negedge clk);

        in_valid = 1'b1; inst_code = W_ADDI;
        @(negedge clk);
        inst_code = W_JAL;
        check("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt", 64'(fmt64), 64'd1);
        @(negedge clk);
        inst_code = W_SRAI;
        check("jal_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("jal_fmt", 64'(fmt64), 64'd5);
        @(negedge clk);
        inst_code = W_BAD;
        check("srai_imm", 64'(imm32), 64'd3);
        check("srai_fmt", 64'(fmt32), 64'd7);
        @(negedge clk);
        in_valid = 1'b0;
        check("bad_imm", 64'(imm32), 64'd0);
        check("bad_fmt", 64'(fmt32), 64'd0);
        check("bad_ill", 64'(ill32), 64'd1);
        @(negedge clk);

        // Backpressure: A and B fill the buffer, C waits.
        out_ready = 1'b0; in_valid = 1'b1; inst_code = W_LUI_A;
        @(negedge clk);
        inst_code = W_LUI_B;
        @(negedge clk);
        inst_code = W_CSRWI;
        check("full_ready", 64'(in_ready32), 64'd0);
        repeat (3) @(negedge clk);
        check("stall_imm", 64'(imm32), 64'h12345000);
        check("stall_fmt", 64'(fmt32), 64'd4);
        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready32 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("c_accept_bound", 64'(cyc < 10), 64'd1);
        check("b_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        in_valid = 1'b0;
        check("c_imm", 64'(imm32), 64'd15);
        check("c_fmt", 64'(fmt32), 64'd6);
        repeat (2) @(negedge clk);

        // Flush with a same-cycle push while full.
        out_ready = 1'b0; in_valid = 1'b1; inst_code = W_BEQ;
        @(negedge clk);
        inst_code = W_ADDI;
        @(negedge clk);
        inst_code = W_SRAI; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid64), 64'd0);
        check("flush_ready", 64'(in_ready64), 64'd1);
        @(negedge clk);

        // Reset while full, with push and pop requested.
        in_valid = 1'b1; inst_code = W_JAL;
        @(negedge clk);
        inst_code = W_LUI_B;
        @(negedge clk);
        rst_n = 1'b0; out_ready = 1'b1; inst_code = W_ADDI;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        check("rst2_valid", 64'(out_valid64), 64'd0);
        check("rst2_ready", 64'(in_ready64), 64'd1);
        check("rst2_imm", imm64, 64'd0);
        check("rst2_fmt", 64'(fmt64), 64'd0);
        check("rst2_ill", 64'(ill64), 64'd0);
        @(negedge clk);

        // Directed table with an irregular consumer.
        idx = 0;
        cyc = 0;
        while (idx < 19 && cyc < 200) begin
            out_ready = (cyc % 3) != 0;
            in_valid  = 1'b1;
            inst_code = words[idx];
            acc = in_ready32;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        check("table_bound", 64'(idx), 64'd19);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drain_valid", 64'(out_valid32), 64'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate output; legal values 32 or 64.
REQ-002 Parameter RV64_OPS, default 0, when 1 decodes OP-IMM-32 (0011011); when 0 that opcode is illegal.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 flush  input  1  discard all buffered entries.
REQ-006 in_valid  input  1  inst_code offered.
REQ-007 in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 inst_code  input  32  instruction word.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  consumer takes head entry.
REQ-011 Imm_out  output  XLEN  extended immediate of head entry.
REQ-012 fmt_out  output  3  format code: 0 N, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shift amount).
REQ-013 illegal_out  output  1  head entry opcode unrecognised.

Function
REQ-014 Decode is combinational on inst_code; result (Imm_out, fmt_out, illegal_out) is written into a 2-entry FIFO on push = in_valid & in_ready.
REQ-015 Latency: entry pushed in cycle N is visible on outputs with out_valid=1 in cycle N+1 at earliest.
REQ-016 I: opcodes 0000011, 1100111, and 0010011 with funct3 not 001/101 -> sign-extend inst[31:20], fmt 1.
REQ-017 SH: 0010011 with funct3 001/101 -> zero-extend inst[24:20] (XLEN 32) or inst[25:20] (XLEN 64), fmt 7; funct7 bits never appear in Imm_out.
REQ-018 S: 0100011 -> sign-extend {inst[31:25], inst[11:7]}, fmt 2.
REQ-019 B: 1100011 -> sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}, fmt 3.
REQ-020 U: 0110111, 0010111 -> {inst[31:12], 12'b0} sign-extended from bit 31 to XLEN, fmt 4.
REQ-021 J: 1101111 -> sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}, fmt 5.
REQ-022 Z: 1110011 with funct3[2]=1 -> zero-extend inst[19:15], fmt 6; 1110011 with funct3[2]=0 -> Imm_out 0, fmt 0.
REQ-023 OP-IMM-32 (RV64_OPS=1): as REQ-016/017 but shift amount always inst[24:20].
REQ-024 N: 0110011, 0111011 (RV64_OPS=1 only), 0001111 -> Imm_out 0, fmt 0, illegal 0.
REQ-025 Any other opcode, or inst[1:0] != 11 -> Imm_out 0, fmt 0, illegal 1.
REQ-026 pop = out_valid & out_ready; FIFO read/write pointers 1 bit each, wrap 1->0; count 0..2.
REQ-027 in_ready = (count != 2), derived from registered count only, no combinational path from out_ready.
REQ-028 out_valid = (count != 0); when count = 0, Imm_out, fmt_out, illegal_out drive 0.
REQ-029 Simultaneous push and pop at count 1: count stays 1, new entry becomes head next cycle; at count 2 no push occurs.
REQ-030 Push while empty and pop-attempt same cycle: pop ignored (out_valid=0), count -> 1.
REQ-031 Outputs hold stable while out_valid=1 and out_ready=0.
REQ-032 flush: next cycle count 0, pointers 0; flush overrides same-cycle push and pop (both discarded).

Reset
REQ-033 rst_n=0 at a rising edge: count 0, pointers 0, out_valid 0, in_ready 1 next cycle, Imm_out 0, fmt_out 0, illegal_out 0; reset overrides flush, push, pop.
REQ-034 Reset asserted mid-operation with entries buffered discards them; no entry emerges after reset release.

Verification
REQ-035 XLEN 32, push 0x00320463 (beq x4,x3,8), out_ready=1 -> next cycle out_valid 1, Imm_out 0x00000008, fmt 3, illegal 0.
REQ-036 XLEN 64, push 0xFFF00093 (addi x1,x0,-1) -> Imm_out 0xFFFFFFFFFFFFFFFF, fmt 1; push 0xFFDFF06F (jal x0,-4) -> 0xFFFFFFFFFFFFFFFC, fmt 5.
REQ-037 Push 0x4032D293 (srai x5,x5,3) -> Imm_out 3, fmt 7; push 0x0000000B -> Imm_out 0, fmt 0, illegal 1.
REQ-038 out_ready=0, offer 3 consecutive words A,B,C -> A,B accepted, in_ready 0 from cycle after B; out_ready=1 -> A then B then C in order, outputs stable while stalled.
REQ-039 Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid 0, in_ready 1, pushed word lost.
REQ-040 Two entries buffered, rst_n=0 one cycle -> next cycle out_valid 0, all outputs 0, in_ready 1.
